// File: rtl/apb_reg_completer.sv
`default_nettype none
// ============================================================================
//  Module   : apb_reg_completer
//  Purpose  : APB completer holding NUM_REGS word-indexed registers. Services
//             single read/write transfers with WAIT_CYCLES wait states, flags
//             out-of-range indices on PSLVERR and exposes a registered debug
//             read port that needs no bus traffic.
//  Ports    : PCLK      - bus clock, rising edge
//             PRESET    - asynchronous active-low reset
//             PSEL      - completer select
//             PENABLE   - access phase qualifier
//             PWRITE    - 1 = write, 0 = read
//             PRWADDR   - register (word) index
//             PRWDATA   - write data
//             PRDATA1   - read data, valid with PREADY on reads
//             PREADY    - transfer completes in the cycle it is high
//             PSLVERR   - error qualifier, valid with PREADY
//             dbg_idx   - debug register select
//             dbg_data  - registered copy of reg[dbg_idx], 1-cycle latency
//  Revision : 1.0 - initial release
// ============================================================================
module apb_reg_completer #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 4,
    parameter int WAIT_CYCLES = 1,
    parameter int IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PRWADDR,
    input  logic [DATA_W-1:0] PRWDATA,
    output logic [DATA_W-1:0] PRDATA1,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [IDX_W-1:0]  dbg_idx,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int                CNT_W        = 4;
    localparam logic [CNT_W-1:0]  c_WAIT_LOAD  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic              c_HAS_WAIT   = (WAIT_CYCLES > 0);
    localparam logic [ADDR_W-1:0] c_NUM_REGS_A = ADDR_W'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_latch;
    logic               w_complete;

    // Transfer attributes captured at SETUP entry
    logic [ADDR_W-1:0]  r_addr;
    logic               r_write;
    logic [DATA_W-1:0]  r_wdata;

    logic [DATA_W-1:0]  r_regs [NUM_REGS];
    logic [DATA_W-1:0]  r_prdata;
    logic               r_pready;
    logic               r_pslverr;
    logic [DATA_W-1:0]  r_dbg;

    logic               w_in_range;
    logic [IDX_W-1:0]   w_idx;
    logic               w_dbg_ok;
    logic               w_setup_req;
    logic               w_access;

    // Full-width compare so any set upper address bit counts as out of range
    assign w_in_range  = (r_addr < c_NUM_REGS_A);
    assign w_idx       = r_addr[IDX_W-1:0];
    // Only matters when NUM_REGS is not a power of two
    assign w_dbg_ok    = (32'(dbg_idx) < 32'(NUM_REGS));
    assign w_setup_req = PSEL && !PENABLE;
    assign w_access    = PSEL && PENABLE;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // PENABLE high without a preceding setup phase is ignored
                if (w_setup_req) begin
                    w_state_next = S_SETUP;
                    w_latch      = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_access) begin
                    if (c_HAS_WAIT) begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = c_WAIT_LOAD;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!w_access) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                // Response registers load on this edge, so PREADY is
                // visible in the cycle following DONE.
                w_complete = 1'b1;
                if (w_setup_req) begin
                    w_state_next = S_SETUP;
                    w_latch      = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: capture, commit, response and debug registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_dbg     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_latch) begin
                r_addr  <= PRWADDR;
                r_write <= PWRITE;
                r_wdata <= PRWDATA;
            end

            r_pready  <= w_complete;
            r_pslverr <= w_complete && !w_in_range;
            r_prdata  <= (w_complete && !r_write && w_in_range) ? r_regs[w_idx] : '0;

            if (w_complete && r_write && w_in_range) begin
                r_regs[w_idx] <= r_wdata;
            end

            // Samples the pre-edge register value, so a coincident write
            // shows up here one cycle later.
            r_dbg <= w_dbg_ok ? r_regs[dbg_idx] : '0;
        end
    end

    assign PRDATA1  = r_prdata;
    assign PREADY   = r_pready;
    assign PSLVERR  = r_pslverr;
    assign dbg_data = r_dbg;

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_completer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_reg_completer
//  Purpose  : Self-checking bench for apb_reg_completer: vector table for the
//             directed transfers, hand sequences for abort / reset / debug
//             timing, and randomized transfers against a register-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_reg_completer;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int NUM_REGS    = 4;
    localparam int WAIT_CYCLES = 1;
    localparam int IDX_W       = 2;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PRWADDR;
    logic [DATA_W-1:0] PRWDATA;
    logic [DATA_W-1:0] PRDATA1;
    logic              PREADY;
    logic              PSLVERR;
    logic [IDX_W-1:0]  dbg_idx;
    logic [DATA_W-1:0] dbg_data;

    apb_reg_completer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_REGS    (NUM_REGS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PRWADDR  (PRWADDR),
        .PRWDATA  (PRWDATA),
        .PRDATA1  (PRDATA1),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain register array
    logic [DATA_W-1:0] model [NUM_REGS];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(NUM_REGS);
    endfunction

    // Full APB transfer; returns response plus latency counted in edges
    // after the first edge that samples PENABLE=1.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input bit scramble,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic [31:0] dbg_at_ready);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PRWADDR = addr; PRWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        lat = -1; rdata = '0; err = 1'b0; dbg_at_ready = '0;
        for (int n = 0; n < 40; n++) begin
            @(posedge PCLK); #1;
            if (PREADY === 1'b1) begin
                lat = n; rdata = PRDATA1; err = PSLVERR; dbg_at_ready = dbg_data;
                break;
            end
            if (scramble) begin
                PRWADDR = $urandom; PRWDATA = $urandom; PWRITE = 1'($urandom);
            end
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL xfer_timeout: got no PREADY expected PREADY within 40 cycles");
        end
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRWADDR = $urandom; PRWDATA = $urandom;
        @(posedge PCLK); #1;
        chk("pready_one_cycle", 32'(PREADY), 32'd0);
        chk("prdata_returns_0", PRDATA1, 32'd0);
    endtask

    task automatic dbg_chk(input int i);
        dbg_idx = IDX_W'(i);
        @(posedge PCLK); #1;
        chk($sformatf("dbg_data[%0d]", i), dbg_data, model[i]);
    endtask

    initial begin
        logic [31:0] rd, dbg_r, addr, data;
        logic        err;
        int          lat;
        bit          wr;

        vecs[0]  = '{1'b1, 32'd0,          32'h00000309, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'd1,          32'h07122023, 32'h0,        1'b0};
        vecs[2]  = '{1'b1, 32'd2,          32'h444F4C5A, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'd3,          32'h44454E49, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'd2,          32'h0,        32'h444F4C5A, 1'b0};
        vecs[5]  = '{1'b1, 32'd4,          32'hDEADBEEF, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'd4,          32'h0,        32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'd0,          32'h0,        32'h00000309, 1'b0};
        vecs[8]  = '{1'b0, 32'd1,          32'h0,        32'h07122023, 1'b0};
        vecs[9]  = '{1'b0, 32'd3,          32'h0,        32'h44454E49, 1'b0};
        vecs[10] = '{1'b1, 32'h80000001,   32'h13572468, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 32'h00010002,   32'h0,        32'h0,        1'b1};

        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

        // ---- reset ----
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PRWADDR = '0; PRWDATA = '0; dbg_idx = '0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_pready",  32'(PREADY),  32'd0);
        chk("reset_pslverr", 32'(PSLVERR), 32'd0);
        chk("reset_prdata",  PRDATA1,      32'd0);
        @(negedge PCLK); PRESET = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) dbg_chk(i);

        // ---- directed vector table ----
        for (int v = 0; v < 12; v++) begin
            xfer(vecs[v].wr, vecs[v].addr, vecs[v].data, 1'b0, rd, err, lat, dbg_r);
            chk($sformatf("vec%0d_pslverr", v), 32'(err), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(WAIT_CYCLES + 1));
            if (!vecs[v].wr) chk($sformatf("vec%0d_prdata", v), rd, vecs[v].exp_rd);
            if (vecs[v].wr && in_range(vecs[v].addr)) model[vecs[v].addr[IDX_W-1:0]] = vecs[v].data;
        end
        for (int i = 0; i < NUM_REGS; i++) dbg_chk(i);

        // ---- PENABLE without setup phase: no response ----
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PRWADDR = 32'd2; PRWDATA = 32'hCAFEF00D;
        for (int n = 0; n < 4; n++) begin
            @(posedge PCLK); #1;
            chk("no_setup_pready", 32'(PREADY), 32'd0);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        dbg_chk(2);

        // ---- abort during WAIT ----
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PRWADDR = 32'd1; PRWDATA = 32'hFFFFFFFF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge PCLK); #1;
            chk("abort_pready", 32'(PREADY), 32'd0);
        end
        dbg_chk(1);

        // ---- coincident write and debug read of the same index ----
        dbg_idx = '0;
        xfer(1'b1, 32'd0, 32'h0BADF00D, 1'b0, rd, err, lat, dbg_r);
        chk("dbg_old_at_commit", dbg_r, model[0]);
        model[0] = 32'h0BADF00D;
        chk("dbg_new_after", dbg_data, model[0]);

        // ---- async reset during WAIT of a write to idx 3 ----
        dbg_idx = 2'd3;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PRWADDR = 32'd3; PRWDATA = 32'h12345678;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #2;
        PRESET = 1'b0;
        #1;
        chk("areset_pready",  32'(PREADY),  32'd0);
        chk("areset_pslverr", 32'(PSLVERR), 32'd0);
        chk("areset_prdata",  PRDATA1,      32'd0);
        chk("areset_dbg",     dbg_data,     32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        @(negedge PCLK); PRESET = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) dbg_chk(i);
        xfer(1'b1, 32'd3, 32'hA5A5A5A5, 1'b0, rd, err, lat, dbg_r);
        chk("post_reset_err", 32'(err), 32'd0);
        chk("post_reset_lat", 32'(lat), 32'(WAIT_CYCLES + 1));
        model[3] = 32'hA5A5A5A5;
        dbg_chk(3);

        // ---- randomized transfers against the model ----
        for (int t = 0; t < 60; t++) begin
            int r;
            r    = int'($urandom_range(0, 9));
            wr   = 1'($urandom);
            data = $urandom;
            if (r < 7)       addr = 32'(r % NUM_REGS);
            else if (r == 7) addr = 32'(NUM_REGS) + 32'($urandom_range(0, 8));
            else             addr = $urandom | 32'h00100000;
            xfer(wr, addr, data, 1'($urandom), rd, err, lat, dbg_r);
            chk($sformatf("rnd%0d_err", t), 32'(err), 32'(!in_range(addr)));
            chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(WAIT_CYCLES + 1));
            if (!wr) chk($sformatf("rnd%0d_rdata", t), rd,
                         in_range(addr) ? model[addr[IDX_W-1:0]] : 32'd0);
            if (wr && in_range(addr)) model[addr[IDX_W-1:0]] = data;
            if (t % 5 == 4) dbg_chk(int'($urandom_range(0, NUM_REGS - 1)));
        end
        for (int i = 0; i < NUM_REGS; i++) dbg_chk(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
